keypad_sprite_mover: RTL and testbench
======================================

# keypad_sprite_mover

Parametrised keypad-driven sprite controller for the VGA text-mode framebuffer. It holds one sprite position on a configurable character grid and moves it one cell per keypad press. Each move erases the old cell and draws a direction-dependent glyph at the new cell, with auto-repeat pacing from the free-running timer. At the grid edge it either clamps or wraps, selected by parameter. It sits between the keypad decoder and the VGA text RAM write port, in place of hand-unrolled per-direction state sequences.

## Interface
- COLS, 80: grid columns; row stride of the text RAM.
- ROWS, 30: grid rows.
- BORDER, 2: margin cells on every side. Legal columns are BORDER..COLS-1-BORDER; legal rows are BORDER..ROWS-1-BORDER.
- START_COL / START_ROW, 10 / 10: position after reset. Must be inside the legal range.
- WRAP, 0: 0 clamps at the edge; 1 wraps to the opposite legal edge.
- REPEAT_TICKS, 100: minimum timer ticks between successive moves.
- ADDR_W, 12: width of vga_addr. COLS*ROWS must be at most 2^ADDR_W.
- ATTR, 8'h0e: attribute byte for sprite glyphs.
- GLYPH_L / GLYPH_R / GLYPH_D / GLYPH_U, 8'h03 / 8'h01 / 8'h04 / 8'h02: character code per facing.
- BG_WORD, 16'h0000: word written when erasing a cell.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-low.
- timer, input, 32: free-running tick counter. Wraps modulo 2^32.
- keypad, input, 8: bit0 left, bit1 right, bit2 down, bit3 up. Bits 7:4 are ignored.
- vga_addr, output, ADDR_W: text RAM write address.
- vga_we, output, 1: write strobe; one cycle per write.
- vga_data, output, 16: {attr, char}.
- pos_col, output, 7: current column.
- pos_row, output, 7: current row.
- busy, output, 1: high in every state except IDLE.

## Operation
- FSM states: INIT, IDLE, ERASE, DRAW, HOLD.
- INIT: write the GLYPH_R word at START_ROW*COLS+START_COL, then go to IDLE.
- IDLE: sample keypad with fixed priority bit0 > bit1 > bit2 > bit3. With no bit set, stay in IDLE.
- On a key press:
  - Latch the facing and compute the candidate position.
  - Clamp mode: a step beyond a legal edge leaves that coordinate unchanged.
  - Wrap mode: a step beyond the min edge goes to the max edge, and a step beyond the max edge goes to the min edge.
- If the candidate differs from the current position, go to ERASE, then DRAW.
- If the candidate equals the current position (clamped), skip ERASE and go straight to DRAW, which redraws the facing glyph only.
- ERASE: write BG_WORD at the old address.
- DRAW: write {ATTR, glyph[facing]} at the new address, commit pos_col/pos_row, and capture t0 = timer.
- HOLD: leave when (timer - t0) >= REPEAT_TICKS, using 32-bit modular subtraction so the test is correct across timer wrap. Go to IDLE.
- Address arithmetic: row*COLS+col computed at full width and truncated to ADDR_W.
- Keys held continuously auto-repeat at one move per REPEAT_TICKS.

## Timing
- Reset values:
  - State INIT.
  - vga_we 0, vga_addr 0, vga_data 0.
  - pos_col = START_COL, pos_row = START_ROW.
  - busy 1.
- vga_addr, vga_data and vga_we are registered outputs, all valid in the same cycle. vga_we is high only in the cycle the FSM occupies INIT, ERASE or DRAW.
- First INIT write: cycle 1 after reset deassertion. IDLE is reached at cycle 2.
- Key sampled in IDLE at cycle N: ERASE write at N+1, DRAW write at N+2, HOLD from N+3. pos_* update at the DRAW edge, visible at N+3.
- Clamped press: DRAW write at N+1.
- keypad changes during ERASE, DRAW or HOLD are ignored. Only the IDLE sample matters.
- Simultaneous keys: the priority encoder decides; exactly one move per cycle sequence.
- Reset asserted mid-sequence: all outputs and state return to reset values immediately. A partially completed move leaves the old glyph in RAM; this is accepted.
- REPEAT_TICKS = 0: HOLD exits after one cycle.

## Structure
- Package kpm_pkg holds:
  - State enum.
  - Direction enum (DIR_L, DIR_R, DIR_D, DIR_U).
  - Keypad bit indices.
  - Default glyph and attribute constants.
- Sub-module sprite_step: combinational next-position on (col, row, dir, WRAP, bounds). It returns the new coordinates plus a "moved" flag and is reused by the future ghost controllers.
- The top level holds the FSM, position registers, timer compare and output registers.

## Test plan
- Reset release with defaults: a single write at cycle 1 with addr 810, data 16'h0e01. Then idle, with busy 0 from cycle 2.
- Pulse bit1 from (10,10): ERASE addr 810, data 0000, then DRAW addr 811, data 0e01. pos_col becomes 11, and there are no further writes for 100 ticks.
- Clamp mode, col = 77, bit1 held: only DRAW writes at addr 10*80+77, pos_col stays 77, repeated every 100 ticks.
- WRAP=1, col = 2, pulse bit0: ERASE at row*80+2, DRAW at row*80+77 with glyph 0e03.
- Keypad 4'b1111 in IDLE: a left move only (glyph 03). Timer preset to 32'hFFFF_FFC0 before DRAW: HOLD exits exactly 100 ticks later despite the wrap.
- Assert rst during HOLD and during ERASE: outputs return to reset values within the same cycle, with no spurious vga_we. The INIT write is at 810 after release.

Source files
------------

// File: rtl/kpm_pkg.sv
// Shared types and constants for the keypad sprite mover and its step helper.
// Holds the FSM state enum, the facing enum, keypad bit positions, default
// glyph/attribute words and the keypad priority encoder.
package kpm_pkg;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StErase,
    StDraw,
    StHold
  } state_e;

  typedef enum logic [1:0] {
    DIR_L,
    DIR_R,
    DIR_D,
    DIR_U
  } dir_e;

  localparam int unsigned KeyLeft  = 0;
  localparam int unsigned KeyRight = 1;
  localparam int unsigned KeyDown  = 2;
  localparam int unsigned KeyUp    = 3;

  localparam logic [7:0]  DefAttr   = 8'h0e;
  localparam logic [7:0]  DefGlyphL = 8'h03;
  localparam logic [7:0]  DefGlyphR = 8'h01;
  localparam logic [7:0]  DefGlyphD = 8'h04;
  localparam logic [7:0]  DefGlyphU = 8'h02;
  localparam logic [15:0] DefBgWord = 16'h0000;

  // Fixed priority left > right > down > up. Only meaningful when some bit is set.
  function automatic dir_e key_to_dir(logic [3:0] keys);
    if (keys[KeyLeft]) begin
      return DIR_L;
    end else if (keys[KeyRight]) begin
      return DIR_R;
    end else if (keys[KeyDown]) begin
      return DIR_D;
    end
    return DIR_U;
  endfunction

endpackage

// File: rtl/sprite_step.sv
// Combinational one-cell step on a bordered character grid.
// Ports:
//   col, row         current position
//   dir              step direction
//   new_col, new_row position after the step (clamped or wrapped at the edge)
//   moved            high when the step changed the position
module sprite_step
  import kpm_pkg::*;
#(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned BORDER = 2,
  parameter int unsigned WRAP   = 0
) (
  input  logic [6:0] col,
  input  logic [6:0] row,
  input  dir_e       dir,
  output logic [6:0] new_col,
  output logic [6:0] new_row,
  output logic       moved
);

  localparam logic [6:0] ColMin = 7'(BORDER);
  localparam logic [6:0] ColMax = 7'(COLS - 1 - BORDER);
  localparam logic [6:0] RowMin = 7'(BORDER);
  localparam logic [6:0] RowMax = 7'(ROWS - 1 - BORDER);

  always_comb begin
    new_col = col;
    new_row = row;
    case (dir)
      DIR_L: begin
        if (col > ColMin)     new_col = col - 7'd1;
        else if (WRAP != 0)   new_col = ColMax;
      end
      DIR_R: begin
        if (col < ColMax)     new_col = col + 7'd1;
        else if (WRAP != 0)   new_col = ColMin;
      end
      DIR_D: begin
        if (row < RowMax)     new_row = row + 7'd1;
        else if (WRAP != 0)   new_row = RowMin;
      end
      default: begin
        if (row > RowMin)     new_row = row - 7'd1;
        else if (WRAP != 0)   new_row = RowMax;
      end
    endcase
    moved = (new_col != col) || (new_row != row);
  end

endmodule

// File: rtl/keypad_sprite_mover.sv
// Keypad-driven sprite controller writing into the VGA text RAM.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   timer               free-running tick counter used for auto-repeat pacing
//   keypad              bit0 left, bit1 right, bit2 down, bit3 up (7:4 ignored)
//   vga_addr/we/data    registered text RAM write port, data = {attr, char}
//   pos_col, pos_row    committed sprite position
//   busy                high whenever the controller is not idle
module keypad_sprite_mover
  import kpm_pkg::*;
#(
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 30,
  parameter int unsigned BORDER       = 2,
  parameter int unsigned START_COL    = 10,
  parameter int unsigned START_ROW    = 10,
  parameter int unsigned WRAP         = 0,
  parameter int unsigned REPEAT_TICKS = 100,
  parameter int unsigned ADDR_W       = 12,
  parameter logic [7:0]  ATTR         = DefAttr,
  parameter logic [7:0]  GLYPH_L      = DefGlyphL,
  parameter logic [7:0]  GLYPH_R      = DefGlyphR,
  parameter logic [7:0]  GLYPH_D      = DefGlyphD,
  parameter logic [7:0]  GLYPH_U      = DefGlyphU,
  parameter logic [15:0] BG_WORD      = DefBgWord
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       timer,
  input  logic [7:0]        keypad,
  output logic [ADDR_W-1:0] vga_addr,
  output logic              vga_we,
  output logic [15:0]       vga_data,
  output logic [6:0]        pos_col,
  output logic [6:0]        pos_row,
  output logic              busy
);

  localparam logic [6:0] StartCol = 7'(START_COL);
  localparam logic [6:0] StartRow = 7'(START_ROW);

  function automatic logic [ADDR_W-1:0] cell_addr(logic [6:0] c, logic [6:0] r);
    logic [31:0] full;
    full = 32'(r) * 32'(COLS) + 32'(c);
    return full[ADDR_W-1:0];
  endfunction

  function automatic logic [7:0] glyph_of(dir_e d);
    case (d)
      DIR_L:   return GLYPH_L;
      DIR_R:   return GLYPH_R;
      DIR_D:   return GLYPH_D;
      default: return GLYPH_U;
    endcase
  endfunction

  state_e      state_q;
  dir_e        dir_q;
  logic [6:0]  new_col_q, new_row_q;
  logic [31:0] t0_q;

  dir_e       key_dir;
  logic [6:0] step_col, step_row;
  logic       step_moved;
  logic       key_hit;
  logic       unused_keys;

  assign key_dir     = key_to_dir(keypad[3:0]);
  assign key_hit     = |keypad[3:0];
  assign unused_keys = ^keypad[7:4];
  assign busy        = (state_q != StIdle);

  sprite_step #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .BORDER(BORDER),
    .WRAP  (WRAP)
  ) u_step (
    .col    (pos_col),
    .row    (pos_row),
    .dir    (key_dir),
    .new_col(step_col),
    .new_row(step_row),
    .moved  (step_moved)
  );

  // Write outputs are registered together with the state that owns them, so the
  // strobe is visible in exactly the cycle the FSM sits in INIT, ERASE or DRAW.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StInit;
      dir_q     <= DIR_R;
      new_col_q <= StartCol;
      new_row_q <= StartRow;
      t0_q      <= '0;
      pos_col   <= StartCol;
      pos_row   <= StartRow;
      vga_we    <= 1'b0;
      vga_addr  <= '0;
      vga_data  <= '0;
    end else begin
      vga_we <= 1'b0;
      case (state_q)
        StInit: begin
          // First cycle out of reset issues the write; the strobe marks it done.
          if (!vga_we) begin
            vga_we   <= 1'b1;
            vga_addr <= cell_addr(StartCol, StartRow);
            vga_data <= {ATTR, GLYPH_R};
          end else begin
            state_q <= StIdle;
          end
        end
        StIdle: begin
          if (key_hit) begin
            dir_q     <= key_dir;
            new_col_q <= step_col;
            new_row_q <= step_row;
            vga_we    <= 1'b1;
            if (step_moved) begin
              state_q  <= StErase;
              vga_addr <= cell_addr(pos_col, pos_row);
              vga_data <= BG_WORD;
            end else begin
              // Clamped: only refresh the facing glyph in place.
              state_q  <= StDraw;
              vga_addr <= cell_addr(step_col, step_row);
              vga_data <= {ATTR, glyph_of(key_dir)};
            end
          end
        end
        StErase: begin
          state_q  <= StDraw;
          vga_we   <= 1'b1;
          vga_addr <= cell_addr(new_col_q, new_row_q);
          vga_data <= {ATTR, glyph_of(dir_q)};
        end
        StDraw: begin
          pos_col <= new_col_q;
          pos_row <= new_row_q;
          t0_q    <= timer;
          state_q <= StHold;
        end
        StHold: begin
          // Modular difference stays correct across timer wrap.
          if ((timer - t0_q) >= REPEAT_TICKS) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_sprite_mover.sv
module tb_keypad_sprite_mover;

  localparam int Cols = 80;
  localparam int Lo   = 2;
  localparam int ColHi = 77;
  localparam int RowHi = 27;
  localparam int Rpt  = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] timer;
  logic [7:0]  keypad = 8'h00;

  logic [11:0] addr0, addr1;
  logic        we0, we1, busy0, busy1;
  logic [15:0] data0, data1;
  logic [6:0]  col0, row0, col1, row1;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  int          tstep = 1;
  bit          tload = 1'b0;
  logic [31:0] tload_val = '0;

  int log0a[$], log0d[$], log1a[$], log1d[$];

  keypad_sprite_mover dut0 (
    .clk(clk), .rst(rst), .timer(timer), .keypad(keypad),
    .vga_addr(addr0), .vga_we(we0), .vga_data(data0),
    .pos_col(col0), .pos_row(row0), .busy(busy0)
  );

  keypad_sprite_mover #(.WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .timer(timer), .keypad(keypad),
    .vga_addr(addr1), .vga_we(we1), .vga_data(data1),
    .pos_col(col1), .pos_row(row1), .busy(busy1)
  );

  always #5 clk = ~clk;

  initial begin
    timer = '0;
    forever begin
      @(posedge clk);
      #2;
      if (tload) begin
        timer = tload_val;
        tload = 1'b0;
      end else begin
        timer = timer + 32'(tstep);
      end
    end
  end

  // ---------------- behavioural model ----------------
  // Tracks position and a short list of pending writes per move, not FSM states.
  typedef struct packed {
    int          col;
    int          row;
    int          stage;   // 0 just reset, 1 init write shown, 2 running
    int          wc;      // writes still to show after the current one
    int          qa;
    int          qd;
    bit          commit;
    int          ncol;
    int          nrow;
    bit          hold;
    logic [31:0] t0;
    bit          we;
    bit          busy;
    int          addr;
    int          data;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m = '0;
    m.col = 10;
    m.row = 10;
    m.busy = 1'b1;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m_in, logic [7:0] kp, logic [31:0] tm, bit wrap);
    mdl_t m;
    int dc, dr, g, nc, nr, draw_a, draw_d;
    m = m_in;
    m.we = 1'b0;
    m.busy = 1'b1;
    dc = 0;
    dr = 0;
    g = 0;
    if (m.stage == 0) begin
      m.stage = 1;
      m.we = 1'b1;
      m.addr = 10 * Cols + 10;
      m.data = 'h0e01;
      return m;
    end
    if (m.stage == 1) begin
      m.stage = 2;
      m.busy = 1'b0;
      return m;
    end
    if (m.commit) begin
      m.col = m.ncol;
      m.row = m.nrow;
      m.commit = 1'b0;
      m.hold = 1'b1;
      m.t0 = tm;
      return m;
    end
    if (m.wc > 0) begin
      m.we = 1'b1;
      m.addr = m.qa;
      m.data = m.qd;
      m.wc = 0;
      m.commit = 1'b1;
      return m;
    end
    if (m.hold) begin
      if (tm - m.t0 >= 32'(Rpt)) begin
        m.hold = 1'b0;
        m.busy = 1'b0;
      end
      return m;
    end
    m.busy = 1'b0;
    if (kp[3:0] != 4'h0) begin
      if (kp[0])      begin dc = -1; g = 'h03; end
      else if (kp[1]) begin dc = 1;  g = 'h01; end
      else if (kp[2]) begin dr = 1;  g = 'h04; end
      else            begin dr = -1; g = 'h02; end
      nc = m.col + dc;
      nr = m.row + dr;
      if (nc < Lo)    nc = wrap ? ColHi : m.col;
      if (nc > ColHi) nc = wrap ? Lo : m.col;
      if (nr < Lo)    nr = wrap ? RowHi : m.row;
      if (nr > RowHi) nr = wrap ? Lo : m.row;
      m.ncol = nc;
      m.nrow = nr;
      draw_a = nr * Cols + nc;
      draw_d = ('h0e << 8) | g;
      m.we = 1'b1;
      m.busy = 1'b1;
      if (nc != m.col || nr != m.row) begin
        m.addr = m.row * Cols + m.col;
        m.data = 0;
        m.qa = draw_a;
        m.qd = draw_d;
        m.wc = 1;
      end else begin
        m.addr = draw_a;
        m.data = draw_d;
        m.commit = 1'b1;
      end
    end
    return m;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0 = mdl_reset();
      m1 = mdl_reset();
    end else begin
      m0 = mdl_step(m0, keypad, timer, 1'b0);
      m1 = mdl_step(m1, keypad, timer, 1'b1);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input mdl_t m, input logic we, input logic [11:0] a,
                     input logic [15:0] d, input logic b, input logic [6:0] c,
                     input logic [6:0] r);
    chk({tag, "_we"}, 32'(we), 32'(m.we));
    chk({tag, "_busy"}, 32'(b), 32'(m.busy));
    chk({tag, "_col"}, 32'(c), 32'(m.col));
    chk({tag, "_row"}, 32'(r), 32'(m.row));
    if (m.we || m.stage == 0) begin
      chk({tag, "_addr"}, 32'(a), 32'(m.addr));
      chk({tag, "_data"}, 32'(d), 32'(m.data));
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m0", m0, we0, addr0, data0, busy0, col0, row0);
      cmp("m1", m1, we1, addr1, data1, busy1, col1, row1);
      if (we0) begin log0a.push_back(int'(addr0)); log0d.push_back(int'(data0)); end
      if (we1) begin log1a.push_back(int'(addr1)); log1d.push_back(int'(data1)); end
    end
  end

  task automatic clear_logs();
    log0a.delete(); log0d.delete(); log1a.delete(); log1d.delete();
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy0 && !busy1) return;
    end
    chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic press(input logic [7:0] k);
    bit seen;
    seen = 1'b0;
    keypad = k;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (busy0 && busy1) seen = 1'b1;
    end
    keypad = 8'h00;
    if (!seen) chk("press_busy_timeout", 32'd1, 32'd0);
    wait_idle(400);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  logic [31:0] td;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_we", 32'(we0), 32'd0);
    chk("rst_addr", 32'(addr0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd1);
    chk("rst_col", 32'(col0), 32'd10);

    // Release: INIT write at cycle 1, idle at cycle 2
    rst = 1'b1;
    @(negedge clk);
    chk("init_we", 32'(we0), 32'd1);
    chk("init_addr", 32'(addr0), 32'd810);
    chk("init_data", 32'(data0), 32'h0e01);
    chk("init_busy", 32'(busy0), 32'd1);
    @(negedge clk);
    chk("idle_busy", 32'(busy0), 32'd0);

    // Right pulse from (10,10)
    keypad = 8'h02;
    @(negedge clk);
    keypad = 8'h00;
    chk("erase_addr", 32'(addr0), 32'd810);
    chk("erase_data", 32'(data0), 32'h0000);
    @(negedge clk);
    chk("draw_addr", 32'(addr0), 32'd811);
    chk("draw_data", 32'(data0), 32'h0e01);
    chk("draw_col_old", 32'(col0), 32'd10);
    td = timer;
    @(negedge clk);
    chk("commit_col", 32'(col0), 32'd11);
    clear_logs();
    wait_idle(300);
    chk("hold_ticks", timer - td, 32'd101);
    chk("hold_no_writes", 32'(log0a.size()), 32'd0);

    // All four keys: left wins; timer wraps during HOLD
    keypad = 8'h0f;
    @(negedge clk);
    keypad = 8'h00;
    tload_val = 32'hFFFF_FFC0;
    tload = 1'b1;
    chk("multi_erase_addr", 32'(addr0), 32'd811);
    @(negedge clk);
    chk("multi_draw_addr", 32'(addr0), 32'd810);
    chk("multi_draw_data", 32'(data0), 32'h0e03);
    td = timer;
    wait_idle(300);
    chk("wrap_hold_ticks", timer - td, 32'd101);
    chk("multi_col", 32'(col0), 32'd10);

    // Walk left to the min edge
    tstep = 50;
    for (int i = 0; i < 8; i++) press(8'h01);
    chk("left_edge_col0", 32'(col0), 32'd2);
    chk("left_edge_col1", 32'(col1), 32'd2);

    // One more left: clamp vs wrap
    clear_logs();
    press(8'h01);
    chk("clamp_min_nwr", 32'(log0a.size()), 32'd1);
    if (log0a.size() == 1) begin
      chk("clamp_min_addr", 32'(log0a[0]), 32'd802);
      chk("clamp_min_data", 32'(log0d[0]), 32'h0e03);
    end
    chk("wrap_nwr", 32'(log1a.size()), 32'd2);
    if (log1a.size() == 2) begin
      chk("wrap_erase_addr", 32'(log1a[0]), 32'd802);
      chk("wrap_erase_data", 32'(log1d[0]), 32'h0000);
      chk("wrap_draw_addr", 32'(log1a[1]), 32'd877);
      chk("wrap_draw_data", 32'(log1d[1]), 32'h0e03);
    end
    chk("wrap_col1", 32'(col1), 32'd77);

    // Walk right to the max edge
    for (int i = 0; i < 75; i++) press(8'h02);
    chk("right_edge_col0", 32'(col0), 32'd77);
    chk("right_walk_col1", 32'(col1), 32'd76);

    // Hold right at the edge for 300 cycles, one tick per cycle
    tstep = 1;
    clear_logs();
    keypad = 8'h02;
    repeat (300) @(negedge clk);
    keypad = 8'h00;
    wait_idle(300);
    chk("held_nwr", 32'(log0a.size()), 32'd3);
    foreach (log0a[i]) begin
      chk("held_addr", 32'(log0a[i]), 32'd877);
      chk("held_data", 32'(log0d[i]), 32'h0e01);
    end
    chk("held_col0", 32'(col0), 32'd77);
    chk("held_col1", 32'(col1), 32'd3);

    // Rows: up to the edge, then clamp/wrap, then down
    tstep = 50;
    for (int i = 0; i < 8; i++) press(8'h08);
    chk("up_row0", 32'(row0), 32'd2);
    chk("up_row1", 32'(row1), 32'd2);
    press(8'h08);
    chk("up_clamp_row0", 32'(row0), 32'd2);
    chk("up_wrap_row1", 32'(row1), 32'd27);
    press(8'h04);
    chk("down_row0", 32'(row0), 32'd3);
    chk("down_wrap_row1", 32'(row1), 32'd2);

    // Reset during HOLD
    tstep = 1;
    keypad = 8'h01;
    @(negedge clk);
    keypad = 8'h00;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rh_we", 32'(we0), 32'd0);
    chk("rh_addr", 32'(addr0), 32'd0);
    chk("rh_data", 32'(data0), 32'd0);
    chk("rh_busy", 32'(busy0), 32'd1);
    chk("rh_col", 32'(col0), 32'd10);
    chk("rh_row", 32'(row0), 32'd10);
    chk("rh_we1", 32'(we1), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rh_init_we", 32'(we0), 32'd1);
    chk("rh_init_addr", 32'(addr0), 32'd810);
    @(negedge clk);

    // Reset during ERASE
    keypad = 8'h02;
    @(posedge clk);
    #1 keypad = 8'h00;
    chk("re_in_erase", 32'(we0), 32'd1);
    rst = 1'b0;
    #1;
    chk("re_we", 32'(we0), 32'd0);
    chk("re_addr", 32'(addr0), 32'd0);
    chk("re_data", 32'(data0), 32'd0);
    chk("re_busy", 32'(busy0), 32'd1);
    chk("re_col", 32'(col0), 32'd10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("re_init_we", 32'(we0), 32'd1);
    chk("re_init_addr", 32'(addr0), 32'd810);
    chk("re_init_data", 32'(data0), 32'h0e01);
    wait_idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
